// File: rtl/nv_nvdla_sdp_hls_y_lut_rd.sv
// SDP Y-path LUT read stage: looks up y0/y1 from the LE/LO tables for each index and registers the result.
// Optional statistics counters are built only when NVDLA_SDP_LUT_RD_STAT_EN is defined.
module nv_nvdla_sdp_hls_y_lut_rd #(
  parameter int LE_DEPTH = 65,
  parameter int LO_DEPTH = 257,
  parameter int DW       = 16
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              idx_in_pvld,
  output logic              idx_in_prdy,
  input  logic [80:0]       idx_in_pd,
  output logic              lut_out_pvld,
  input  logic              lut_out_prdy,
  output logic [80+2*DW:0]  lut_out_pd,
  input  logic              lut_wr_en,
  input  logic              lut_wr_sel,
  input  logic [8:0]        lut_wr_addr,
  input  logic [DW-1:0]     lut_wr_data,
  input  logic              stat_clr,
  output logic [31:0]       stat_oflow_cnt,
  output logic [31:0]       stat_uflow_cnt,
  output logic [31:0]       stat_le_hit_cnt,
  output logic [31:0]       stat_lo_hit_cnt
);

  typedef struct packed {
    logic        lo_hit;
    logic        le_hit;
    logic [8:0]  addr;
    logic        sel;
    logic        uflow;
    logic        oflow;
    logic [31:0] x;
    logic [34:0] frac;
  } idx_pd_t;

  localparam int         LE_AW   = $clog2(LE_DEPTH);
  localparam int         LO_AW   = $clog2(LO_DEPTH);
  localparam logic [9:0] LE_SIZE = 10'(LE_DEPTH);
  localparam logic [9:0] LO_SIZE = 10'(LO_DEPTH);
  localparam logic [8:0] LE_LAST = 9'(LE_DEPTH - 1);
  localparam logic [8:0] LO_LAST = 9'(LO_DEPTH - 1);

  idx_pd_t       in_pd;
  logic          accept;
  logic [8:0]    last_idx;
  logic [8:0]    rd_idx0;
  logic [8:0]    rd_idx1;
  logic [DW-1:0] rd_y0;
  logic [DW-1:0] rd_y1;

  logic [DW-1:0] le_tab [LE_DEPTH];
  logic [DW-1:0] lo_tab [LO_DEPTH];

  assign in_pd       = idx_pd_t'(idx_in_pd);
  assign idx_in_prdy = !lut_out_pvld || lut_out_prdy;
  assign accept      = idx_in_pvld && idx_in_prdy;

  // NOTE: table storage has no reset; contents persist across reset and the
  // arrays stay plain flops without a reset tree.
  always_ff @(posedge nvdla_core_clk) begin
    if (lut_wr_en) begin
      if (lut_wr_sel) begin
        if ({1'b0, lut_wr_addr} < LO_SIZE) begin
          lo_tab[lut_wr_addr[LO_AW-1:0]] <= lut_wr_data;
        end
      end else begin
        if ({1'b0, lut_wr_addr} < LE_SIZE) begin
          le_tab[lut_wr_addr[LE_AW-1:0]] <= lut_wr_data;
        end
      end
    end
  end

  // Index selection: uflow pins to the first entry, oflow or an address at or
  // past the last pair pins both outputs to the last entry.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    last_idx = in_pd.sel ? LO_LAST : LE_LAST;
    rd_idx0  = in_pd.addr;
    rd_idx1  = in_pd.addr + 9'd1;
    if (in_pd.uflow) begin
      rd_idx0 = 9'd0;
      rd_idx1 = 9'd0;
    end else if (in_pd.oflow || (in_pd.addr >= last_idx)) begin
      rd_idx0 = last_idx;
      rd_idx1 = last_idx;
    end
  end

  always_comb begin
    rd_y0 = '0;
    rd_y1 = '0;
    if (in_pd.sel) begin
      rd_y0 = lo_tab[rd_idx0[LO_AW-1:0]];
      rd_y1 = lo_tab[rd_idx1[LO_AW-1:0]];
    end else begin
      rd_y0 = le_tab[rd_idx0[LE_AW-1:0]];
      rd_y1 = le_tab[rd_idx1[LE_AW-1:0]];
    end
  end

  // Output register: a same-edge table write lands after this read samples,
  // so the lookup returns the pre-write value.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      lut_out_pvld <= 1'b0;
      lut_out_pd   <= '0;
    end else if (accept) begin
      lut_out_pvld <= 1'b1;
      lut_out_pd   <= {rd_y1, rd_y0, idx_in_pd};
    end else if (lut_out_prdy) begin
      lut_out_pvld <= 1'b0;
    end
  end

`ifdef NVDLA_SDP_LUT_RD_STAT_EN
  logic [3:0]  stat_hit;
  logic [31:0] stat_cnt [4];

  assign stat_hit = {in_pd.lo_hit, in_pd.le_hit, in_pd.uflow, in_pd.oflow};

  // Saturating event counters; clear wins over a coincident increment.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      for (int i = 0; i < 4; i++) stat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (stat_clr) begin
          stat_cnt[i] <= '0;
        end else if (accept && stat_hit[i] && (stat_cnt[i] != 32'hFFFF_FFFF)) begin
          stat_cnt[i] <= stat_cnt[i] + 32'd1;
        end
      end
    end
  end

  assign stat_oflow_cnt  = stat_cnt[0];
  assign stat_uflow_cnt  = stat_cnt[1];
  assign stat_le_hit_cnt = stat_cnt[2];
  assign stat_lo_hit_cnt = stat_cnt[3];
`else
  logic stat_unused;

  assign stat_unused     = stat_clr;
  assign stat_oflow_cnt  = '0;
  assign stat_uflow_cnt  = '0;
  assign stat_le_hit_cnt = '0;
  assign stat_lo_hit_cnt = '0;
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_hls_y_lut_rd.sv
// Self-checking bench for nv_nvdla_sdp_hls_y_lut_rd against a table/queue reference model.
// Stat expectations follow NVDLA_SDP_LUT_RD_STAT_EN when it is defined.
module tb_nv_nvdla_sdp_hls_y_lut_rd;

  localparam int LE_N = 65;
  localparam int LO_N = 257;
  localparam int DW   = 16;
`ifdef NVDLA_SDP_LUT_RD_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  typedef logic [80+2*DW:0] out_t;

  logic          clk;
  logic          rst;
  logic          idx_in_pvld;
  logic          idx_in_prdy;
  logic [80:0]   idx_in_pd;
  logic          lut_out_pvld;
  logic          lut_out_prdy;
  out_t          lut_out_pd;
  logic          lut_wr_en;
  logic          lut_wr_sel;
  logic [8:0]    lut_wr_addr;
  logic [DW-1:0] lut_wr_data;
  logic          stat_clr;
  logic [31:0]   stat_oflow_cnt;
  logic [31:0]   stat_uflow_cnt;
  logic [31:0]   stat_le_hit_cnt;
  logic [31:0]   stat_lo_hit_cnt;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] le_m [LE_N];
  logic [DW-1:0] lo_m [LO_N];
  out_t          q [$];
  logic [31:0]   exp_cnt [4];

  nv_nvdla_sdp_hls_y_lut_rd #(.LE_DEPTH(LE_N), .LO_DEPTH(LO_N), .DW(DW)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rst  (rst),
    .idx_in_pvld     (idx_in_pvld),
    .idx_in_prdy     (idx_in_prdy),
    .idx_in_pd       (idx_in_pd),
    .lut_out_pvld    (lut_out_pvld),
    .lut_out_prdy    (lut_out_prdy),
    .lut_out_pd      (lut_out_pd),
    .lut_wr_en       (lut_wr_en),
    .lut_wr_sel      (lut_wr_sel),
    .lut_wr_addr     (lut_wr_addr),
    .lut_wr_data     (lut_wr_data),
    .stat_clr        (stat_clr),
    .stat_oflow_cnt  (stat_oflow_cnt),
    .stat_uflow_cnt  (stat_uflow_cnt),
    .stat_le_hit_cnt (stat_le_hit_cnt),
    .stat_lo_hit_cnt (stat_lo_hit_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] tab(input logic s, input int i);
    return s ? lo_m[i] : le_m[i];
  endfunction

  function automatic out_t model_out(input logic [80:0] pd);
    logic          s;
    int            a;
    int            d;
    logic [DW-1:0] y0;
    logic [DW-1:0] y1;
    s = pd[69];
    a = int'(pd[78:70]);
    d = s ? LO_N : LE_N;
    if (pd[68]) begin
      y0 = tab(s, 0);
      y1 = y0;
    end else if (pd[67] || a >= d - 1) begin
      y0 = tab(s, d - 1);
      y1 = y0;
    end else begin
      y0 = tab(s, a);
      y1 = tab(s, a + 1);
    end
    return {y1, y0, pd};
  endfunction

  function automatic void model_write(input logic s, input logic [8:0] a, input logic [DW-1:0] d);
    if (s && int'(a) < LO_N) lo_m[int'(a)] = d;
    if (!s && int'(a) < LE_N) le_m[int'(a)] = d;
  endfunction

  function automatic void model_stat(input logic [80:0] pd);
    logic [3:0] f;
    f = {pd[80], pd[79], pd[68], pd[67]};
    for (int i = 0; i < 4; i++) if (f[i]) exp_cnt[i] = exp_cnt[i] + 1;
  endfunction

  function automatic logic [80:0] mk_pd(input logic s, input logic [8:0] a, input logic of, input logic uf);
    logic [63:0] r;
    logic        lh;
    logic        eh;
    r  = {$urandom(), $urandom()};
    lh = 1'($urandom() % 2);
    eh = 1'($urandom() % 2);
    return {lh, eh, a, s, uf, of, r[63:32], r[34:0]};
  endfunction

  function automatic logic [8:0] rnd_addr(input logic s);
    if ($urandom() % 4 == 0) return 9'($urandom() % 512);
    return s ? 9'($urandom() % 258) : 9'($urandom() % 66);
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input logic v, input logic [80:0] pd, input logic ordy,
                       input logic we, input logic wsel, input logic [8:0] waddr,
                       input logic [DW-1:0] wdata, input logic clr);
    @(posedge clk);
    #1;
    idx_in_pvld  = v;
    idx_in_pd    = pd;
    lut_out_prdy = ordy;
    lut_wr_en    = we;
    lut_wr_sel   = wsel;
    lut_wr_addr  = waddr;
    lut_wr_data  = wdata;
    stat_clr     = clr;
    #1;
    if (we) model_write(wsel, waddr, wdata);
  endtask

  task automatic send(input logic v, input logic [80:0] pd, input logic ordy);
    drive(v, pd, ordy, 1'b0, 1'b0, 9'd0, '0, 1'b0);
  endtask

  task automatic wr(input logic s, input logic [8:0] a, input logic [DW-1:0] d);
    drive(1'b0, '0, 1'b1, 1'b1, s, a, d, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    send(1'b0, '0, 1'b1);
    send(1'b0, '0, 1'b1);
    checks++;
    if (lut_out_pvld !== 1'b0) begin failures++; $display("FAIL reset_pvld: got %b expected 0", lut_out_pvld); end
    checks++;
    if (lut_out_pd !== '0) begin failures++; $display("FAIL reset_pd: got %h expected 0", lut_out_pd); end
    checks++;
    if ({stat_oflow_cnt, stat_uflow_cnt, stat_le_hit_cnt, stat_lo_hit_cnt} !== '0) begin
      failures++; $display("FAIL reset_stats: got %h %h %h %h expected 0", stat_oflow_cnt, stat_uflow_cnt, stat_le_hit_cnt, stat_lo_hit_cnt);
    end
    rst = 1'b0;
    send(1'b0, '0, 1'b0);
    checks++;
    if (idx_in_prdy !== 1'b1) begin failures++; $display("FAIL reset_prdy_after: got %b expected 1", idx_in_prdy); end
  endtask

  task automatic load_tables();
    for (int i = 0; i < LE_N; i++) wr(1'b0, 9'(i), DW'($urandom()));
    for (int i = 0; i < LO_N; i++) wr(1'b1, 9'(i), DW'($urandom()));
    wr(1'b0, 9'd129, 16'hDEAD);
    wr(1'b0, 9'd65, 16'hDEAD);
    wr(1'b1, 9'd300, 16'hDEAD);
  endtask

  task automatic test_basic();
    logic [80:0] pd;
    out_t        e;
    wr(1'b0, 9'd5, 16'h0100);
    wr(1'b0, 9'd6, 16'h0200);
    pd = mk_pd(1'b0, 9'd5, 1'b0, 1'b0);
    e  = model_out(pd);
    send(1'b1, pd, 1'b1);
    checks++;
    if (idx_in_prdy !== 1'b1) begin failures++; $display("FAIL basic_accept: got %b expected 1", idx_in_prdy); end
    send(1'b0, '0, 1'b1);
    checks++;
    if (lut_out_pvld !== 1'b1) begin failures++; $display("FAIL basic_latency: got %b expected 1", lut_out_pvld); end
    checks++;
    if (lut_out_pd[80+2*DW:81] !== {16'h0200, 16'h0100}) begin
      failures++; $display("FAIL basic_y: got %h expected 02000100", lut_out_pd[80+2*DW:81]);
    end
    checks++;
    if (lut_out_pd[80:0] !== pd) begin failures++; $display("FAIL basic_echo: got %h expected %h", lut_out_pd[80:0], pd); end
    checks++;
    if (lut_out_pd !== e) begin failures++; $display("FAIL basic_model: got %h expected %h", lut_out_pd, e); end
    send(1'b0, '0, 1'b1);
    checks++;
    if (lut_out_pvld !== 1'b0) begin failures++; $display("FAIL basic_drop_valid: got %b expected 0", lut_out_pvld); end
  endtask

  task automatic test_boundary();
    logic [11:0] bc [10];
    logic [80:0] pd;
    out_t        e [10];
    bc = '{{1'b1, 9'd256, 1'b0, 1'b0}, {1'b0, 9'd7, 1'b1, 1'b1}, {1'b1, 9'd3, 1'b1, 1'b0},
           {1'b0, 9'd64, 1'b0, 1'b0}, {1'b0, 9'd63, 1'b0, 1'b0}, {1'b1, 9'd255, 1'b0, 1'b0},
           {1'b0, 9'd0, 1'b0, 1'b0},  {1'b0, 9'd300, 1'b0, 1'b0}, {1'b1, 9'd511, 1'b0, 1'b0},
           {1'b0, 9'd10, 1'b0, 1'b1}};
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        pd   = mk_pd(bc[i][11], bc[i][10:2], bc[i][1], bc[i][0]);
        e[i] = model_out(pd);
        send(1'b1, pd, 1'b1);
      end else begin
        send(1'b0, '0, 1'b1);
      end
      if (i > 0) begin
        checks++;
        if (lut_out_pvld !== 1'b1 || lut_out_pd !== e[i-1]) begin
          failures++;
          $display("FAIL boundary_%0d: got v=%b %h expected v=1 %h", i - 1, lut_out_pvld, lut_out_pd, e[i-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic        v_pat [14];
    logic        r_pat [14];
    logic [80:0] pd;
    out_t        e;
    out_t        prev;
    logic        held;
    int          n_out;
    int          n_in;
    v_pat = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    r_pat = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    q.delete();
    held  = 1'b0;
    prev  = '0;
    n_out = 0;
    n_in  = 0;
    for (int c = 0; c < 14; c++) begin
      pd = mk_pd(1'($urandom() % 2), rnd_addr(1'b1), 1'b0, 1'b0);
      e  = model_out(pd);
      send(v_pat[c], pd, r_pat[c]);
      if (c >= 1 && c <= 3) begin
        checks++;
        if (idx_in_prdy !== 1'b0) begin failures++; $display("FAIL stall_prdy_%0d: got %b expected 0", c, idx_in_prdy); end
      end
      if (held) begin
        checks++;
        if (lut_out_pvld !== 1'b1 || lut_out_pd !== prev) begin
          failures++; $display("FAIL stall_hold_%0d: got v=%b %h expected v=1 %h", c, lut_out_pvld, lut_out_pd, prev);
        end
      end
      checks++;
      if (lut_out_pvld !== (q.size() != 0)) begin
        failures++; $display("FAIL stall_valid_%0d: got %b expected %b", c, lut_out_pvld, q.size() != 0);
      end else if (lut_out_pvld) begin
        checks++;
        if (lut_out_pd !== q[0]) begin failures++; $display("FAIL stall_data_%0d: got %h expected %h", c, lut_out_pd, q[0]); end
      end
      held = lut_out_pvld && !lut_out_prdy;
      prev = lut_out_pd;
      if (lut_out_pvld && lut_out_prdy && q.size() != 0) begin
        void'(q.pop_front());
        n_out++;
      end
      if (idx_in_pvld && idx_in_prdy) begin
        q.push_back(e);
        n_in++;
      end
    end
    checks++;
    if (n_in !== 9 || n_out !== 9 || q.size() != 0) begin
      failures++; $display("FAIL stall_count: got in=%0d out=%0d left=%0d expected 9 9 0", n_in, n_out, q.size());
    end
  endtask

  task automatic test_same_cycle_write();
    logic [80:0] pd;
    wr(1'b1, 9'd10, 16'h1111);
    pd = mk_pd(1'b1, 9'd10, 1'b0, 1'b0);
    drive(1'b1, pd, 1'b1, 1'b1, 1'b1, 9'd10, 16'hBEEF, 1'b0);
    send(1'b0, '0, 1'b1);
    checks++;
    if (lut_out_pvld !== 1'b1 || lut_out_pd[80+DW:81] !== 16'h1111) begin
      failures++; $display("FAIL rmw_old: got v=%b y0=%h expected v=1 y0=1111", lut_out_pvld, lut_out_pd[80+DW:81]);
    end
    pd = mk_pd(1'b1, 9'd10, 1'b0, 1'b0);
    send(1'b1, pd, 1'b1);
    send(1'b0, '0, 1'b1);
    checks++;
    if (lut_out_pvld !== 1'b1 || lut_out_pd[80+DW:81] !== 16'hBEEF) begin
      failures++; $display("FAIL rmw_new: got v=%b y0=%h expected v=1 y0=beef", lut_out_pvld, lut_out_pd[80+DW:81]);
    end
  endtask

  task automatic test_reset_stall();
    logic [80:0] pd;
    out_t        e;
    send(1'b1, mk_pd(1'b0, 9'd3, 1'b0, 1'b0), 1'b0);
    send(1'b0, '0, 1'b0);
    checks++;
    if (lut_out_pvld !== 1'b1) begin failures++; $display("FAIL rststall_setup: got %b expected 1", lut_out_pvld); end
    rst = 1'b1;
    send(1'b0, '0, 1'b0);
    checks++;
    if (lut_out_pvld !== 1'b0) begin failures++; $display("FAIL rststall_pvld: got %b expected 0", lut_out_pvld); end
    rst = 1'b0;
    send(1'b0, '0, 1'b0);
    checks++;
    if (idx_in_prdy !== 1'b1) begin failures++; $display("FAIL rststall_prdy: got %b expected 1", idx_in_prdy); end
    send(1'b0, '0, 1'b1);
    send(1'b0, '0, 1'b1);
    checks++;
    if (lut_out_pvld !== 1'b0) begin failures++; $display("FAIL rststall_replay: got %b expected 0", lut_out_pvld); end
    for (int i = 0; i < 2; i++) begin
      pd = mk_pd(1'(i), 9'(5 + 3 * i), 1'b0, 1'b0);
      e  = model_out(pd);
      send(1'b1, pd, 1'b1);
      send(1'b0, '0, 1'b1);
      checks++;
      if (lut_out_pd !== e) begin failures++; $display("FAIL rststall_retain_%0d: got %h expected %h", i, lut_out_pd, e); end
    end
  endtask

  task automatic test_random();
    logic        v;
    logic        r;
    logic        we;
    logic        ws;
    logic        s;
    logic [80:0] pd;
    out_t        e;
    out_t        prev;
    logic        held;
    q.delete();
    held = 1'b0;
    prev = '0;
    for (int c = 0; c < 420; c++) begin
      v  = (c < 400) && ($urandom() % 4 != 0);
      r  = ($urandom() % 4 != 0) || (c >= 400);
      we = (c < 400) && ($urandom() % 3 == 0);
      ws = 1'($urandom() % 2);
      s  = 1'($urandom() % 2);
      pd = mk_pd(s, rnd_addr(s), ($urandom() % 8 == 0), ($urandom() % 8 == 0));
      e  = model_out(pd);
      drive(v, pd, r, we, ws, rnd_addr(ws), DW'($urandom()), 1'b0);
      checks++;
      if (idx_in_prdy !== (!lut_out_pvld || lut_out_prdy)) begin
        failures++; $display("FAIL rnd_prdy_%0d: got %b expected %b", c, idx_in_prdy, !lut_out_pvld || lut_out_prdy);
      end
      if (held) begin
        checks++;
        if (lut_out_pvld !== 1'b1 || lut_out_pd !== prev) begin
          failures++; $display("FAIL rnd_hold_%0d: got v=%b %h expected v=1 %h", c, lut_out_pvld, lut_out_pd, prev);
        end
      end
      checks++;
      if (lut_out_pvld !== (q.size() != 0)) begin
        failures++; $display("FAIL rnd_valid_%0d: got %b expected %b", c, lut_out_pvld, q.size() != 0);
      end else if (lut_out_pvld) begin
        checks++;
        if (lut_out_pd !== q[0]) begin failures++; $display("FAIL rnd_data_%0d: got %h expected %h", c, lut_out_pd, q[0]); end
      end
      held = lut_out_pvld && !lut_out_prdy;
      prev = lut_out_pd;
      if (lut_out_pvld && lut_out_prdy && q.size() != 0) void'(q.pop_front());
      if (idx_in_pvld && idx_in_prdy) q.push_back(e);
    end
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL rnd_drain: got %0d left expected 0", q.size()); end
  endtask

  task automatic test_stats();
    logic [80:0] pd;
    logic [31:0] exp_o;
    rst = 1'b1;
    send(1'b0, '0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = '0;
    for (int c = 0; c < 30; c++) begin
      pd = mk_pd(1'($urandom() % 2), 9'($urandom() % 64), 1'($urandom() % 2), 1'($urandom() % 2));
      send(1'b1, pd, 1'b1);
      if (idx_in_pvld && idx_in_prdy) model_stat(pd);
    end
    send(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) if (!STAT_EN) exp_cnt[i] = '0;
    checks++;
    if ({stat_oflow_cnt, stat_uflow_cnt, stat_le_hit_cnt, stat_lo_hit_cnt} !==
        {exp_cnt[0], exp_cnt[1], exp_cnt[2], exp_cnt[3]}) begin
      failures++;
      $display("FAIL stat_counts: got %0d %0d %0d %0d expected %0d %0d %0d %0d", stat_oflow_cnt, stat_uflow_cnt,
               stat_le_hit_cnt, stat_lo_hit_cnt, exp_cnt[0], exp_cnt[1], exp_cnt[2], exp_cnt[3]);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 9'd0, '0, 1'b1);
    send(1'b0, '0, 1'b1);
    checks++;
    if ({stat_oflow_cnt, stat_uflow_cnt, stat_le_hit_cnt, stat_lo_hit_cnt} !== '0) begin
      failures++; $display("FAIL stat_clear: got %0d %0d %0d %0d expected 0", stat_oflow_cnt, stat_uflow_cnt, stat_le_hit_cnt, stat_lo_hit_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, mk_pd(1'b0, 9'd2, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0, 9'd0, '0, (k == 3));
      if (k == 3) begin
        exp_o = STAT_EN ? 32'd3 : 32'd0;
        checks++;
        if (stat_oflow_cnt !== exp_o) begin failures++; $display("FAIL stat_oflow_pre: got %0d expected %0d", stat_oflow_cnt, exp_o); end
      end
    end
    send(1'b0, '0, 1'b1);
    checks++;
    if (stat_oflow_cnt !== 32'd0) begin failures++; $display("FAIL stat_clr_priority: got %0d expected 0", stat_oflow_cnt); end
  endtask

  initial begin
    rst          = 1'b1;
    idx_in_pvld  = 1'b0;
    idx_in_pd    = '0;
    lut_out_prdy = 1'b0;
    lut_wr_en    = 1'b0;
    lut_wr_sel   = 1'b0;
    lut_wr_addr  = '0;
    lut_wr_data  = '0;
    stat_clr     = 1'b0;
    for (int i = 0; i < LE_N; i++) le_m[i] = '0;
    for (int i = 0; i < LO_N; i++) lo_m[i] = '0;
    test_reset();
    load_tables();
    test_basic();
    test_boundary();
    test_stall();
    test_same_cycle_write();
    test_reset_stall();
    test_random();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_sdp_hls_y_lut_rd.md
NV_NVDLA_SDP_HLS_Y_LUT_RD -- requirements
Module: NV_NVDLA_SDP_HLS_Y_lut_rd

Interface
REQ-001 SHALL have parameter LE_DEPTH, default 65, giving the number of LE table entries.
REQ-002 SHALL have parameter LO_DEPTH, default 257, giving the number of LO table entries.
REQ-003 SHALL have parameter DW, default 16, giving the width of each table entry.
REQ-004 SHALL have nvdla_core_clk  in  1  the single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have nvdla_core_rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have idx_in_pvld / idx_in_prdy  in/out  1/1  input handshake from the Y index stage.
REQ-007 SHALL have idx_in_pd  in  81; fields LSB first:
- frac[34:0]
- x[31:0]
- oflow
- uflow
- sel (0=LE, 1=LO)
- addr[8:0]
- le_hit
- lo_hit
REQ-008 SHALL have lut_out_pvld / lut_out_prdy  out/in  1/1  output handshake to the interpolation stage.
REQ-009 SHALL have lut_out_pd  out  81+2*DW; carries idx_in_pd unchanged in bits [80:0], y0 in [80+DW:81], y1 in [80+2*DW:81+DW].
REQ-010 SHALL have lut_wr_en, lut_wr_sel, lut_wr_addr[8:0], lut_wr_data[DW-1:0]  in; single-cycle table write port.
REQ-011 SHALL have stat_clr  in  1  and stat_oflow_cnt, stat_uflow_cnt, stat_le_hit_cnt, stat_lo_hit_cnt  out  32 each.

Function
REQ-012 SHALL hold the LE and LO tables as flop arrays of DW bits each.
REQ-013 SHALL drive idx_in_prdy = !lut_out_pvld || lut_out_prdy, with no combinational dependency on idx_in_pvld.
REQ-014 SHALL register each accepted input (idx_in_pvld && idx_in_prdy) into the output stage on the next clock edge; latency is exactly 1 cycle.
REQ-015 SHALL hold lut_out_pd and lut_out_pvld stable while lut_out_pvld && !lut_out_prdy.
REQ-016 SHALL clear lut_out_pvld on a cycle where lut_out_prdy=1 and no input is accepted.
REQ-017 SHALL select table T = (sel ? LO : LO/LE accordingly, i.e. LO when sel=1, LE when sel=0) and set D = depth(T).
REQ-018 SHALL set y0=T[0], y1=T[0] when uflow=1.
REQ-019 SHALL set y0=T[D-1], y1=T[D-1] when oflow=1; if uflow and oflow are both set, uflow SHALL take precedence.
REQ-020 SHALL, when neither flag is set and addr >= D-1, clamp both outputs to y0=y1=T[D-1].
REQ-021 SHALL, otherwise, set y0=T[addr] and y1=T[addr+1].
REQ-022 SHALL, on lut_wr_en, write lut_wr_data to table lut_wr_sel at lut_wr_addr on the clock edge.
REQ-023 SHALL silently ignore writes with lut_wr_addr >= depth of the selected table.
REQ-024 SHALL, when a read is accepted in the same cycle as a write to the same entry, return the pre-write value.
REQ-025 SHALL leave x, frac, flags, sel, addr and hits unmodified in lut_out_pd.

Reset
REQ-026 SHALL, on nvdla_core_rst=1 at a clock edge, clear lut_out_pvld to 0 and lut_out_pd to 0.
REQ-027 SHALL clear all stat counters to 0 on reset.
REQ-028 SHALL NOT reset table contents, which persist across reset.
REQ-029 SHALL drop a transaction held in the output stage when reset is asserted mid-operation, and SHALL NOT replay it.
REQ-030 SHALL force idx_in_prdy to 1 in the cycle after reset deasserts.

Configuration
REQ-031 SHALL, with macro NVDLA_SDP_LUT_RD_STAT_EN defined, increment each stat counter by 1 on every accepted input whose matching field (oflow, uflow, le_hit, lo_hit) is 1.
REQ-032 SHALL make the stat counters saturate at 0xFFFFFFFF.
REQ-033 SHALL give stat_clr priority over increment, so the counter reads 0 on the next cycle.
REQ-034 SHALL, without NVDLA_SDP_LUT_RD_STAT_EN, keep all stat ports present, drive them to constant 0, and implement no counter flops.

Verification
REQ-035 SHALL cover: LE[5]=0x0100 and LE[6]=0x0200 written, input sel=0, addr=5, flags=0 -> one cycle later y0=0x0100, y1=0x0200, x/frac echoed.
REQ-036 SHALL cover: sel=1, addr=256 -> y0=y1=LO[256]; sel=0, uflow=1, oflow=1 -> y0=y1=LE[0].
REQ-037 SHALL cover: lut_out_prdy=0 for 3 cycles with input valid -> idx_in_prdy=0 and lut_out_pd stable; prdy=1 -> back-to-back transfers, one per cycle, none lost or duplicated.
REQ-038 SHALL cover: write LO[10]=0xBEEF in the same cycle as an accepted read of addr 10 -> output shows the old value; a repeat read shows 0xBEEF.
REQ-039 SHALL cover: reset asserted while an output is stalled -> lut_out_pvld=0 next cycle, tables retain contents.
REQ-040 SHALL cover, with the macro on: 4 accepted inputs with oflow=1, stat_clr coincident with the 4th -> stat_oflow_cnt=0; with the macro off, all stat outputs stay 0.
